output_port_fifo: RTL
=====================

OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

Interface
REQ-001 Parameter WIDTH, default 17: bit width of each data word, matching the datapath word width.
REQ-002 Parameter DEPTH, default 4: number of FIFO entries; the value SHALL be a power of two and at least 2.
REQ-003 Port Clock, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-004 Port Reset, input, 1: the reset is synchronous and active-high.
REQ-005 Port WriteEnable, input, 1: the CPU requests a write of WriteData this cycle.
REQ-006 Port WriteData, input, WIDTH: the word the CPU writes to the output port.
REQ-007 Port Full, output, 1: high when the count equals DEPTH.
REQ-008 Port OutputData, output, WIDTH: the head-of-FIFO word presented to the external consumer.
REQ-009 Port OutputValid, output, 1: high when OutputData holds a valid word.
REQ-010 Port OutputReady, input, 1: the external consumer accepts OutputData this cycle.
REQ-011 Port Count, output, clog2(DEPTH)+1: the number of occupied entries.
REQ-012 Port Overflow, output, 1: sticky flag that is set when a write is dropped.
REQ-013 Port ClearOverflow, input, 1: clears Overflow on the next rising edge.

Function
REQ-014 The FIFO SHALL be show-ahead: OutputData = mem[read pointer] when Count != 0, and 0 when Count == 0.
REQ-015 OutputValid SHALL equal (Count != 0).
REQ-016 Write accept = WriteEnable and not Full, where Full is the registered value at the start of the cycle.
REQ-017 On write accept: mem[write pointer] <= WriteData, and the write pointer advances by 1, wrapping from DEPTH-1 to 0.
REQ-018 Read handshake = OutputValid and OutputReady.
REQ-019 On read handshake: the read pointer advances by 1 with the same wrap-around rule.
REQ-020 Count update:
- accept only: Count+1
- handshake only: Count-1
- both or neither: Count unchanged
REQ-021 A write to an empty FIFO SHALL have 1-cycle latency: OutputValid rises on the edge that stores the word. There is no same-cycle bypass.
REQ-022 Simultaneous accept and handshake with Count == 1: the new word becomes the head and OutputValid stays high.
REQ-023 WriteEnable while Full is high: the data is dropped, pointers and Count are unchanged, and Overflow <= 1. This holds even if a read handshake occurs in the same cycle, because there is no write-through when full.
REQ-024 OutputReady while OutputValid is low SHALL have no effect.
REQ-025 Overflow priority: a dropped write in the same cycle as ClearOverflow leaves Overflow at 1 (set wins).
REQ-026 Count SHALL never exceed DEPTH and never go below 0. The pointers wrap modulo DEPTH indefinitely.
REQ-027 Words SHALL leave the FIFO in strict write order, with no duplication or loss except the drops defined in REQ-023.

Reset
REQ-028 When Reset is high at a rising edge: both pointers = 0, Count = 0, Overflow = 0, and Full = 0. As a result OutputValid = 0 and OutputData = 0.
REQ-029 Reset SHALL take priority over a simultaneous write, read or ClearOverflow, and any in-flight words are discarded.
REQ-030 The memory array SHALL not require reset. Its contents are unobservable while Count == 0.

Verification
REQ-031 Reset, then write 17'h1ABCD with OutputReady=0 -> on the next cycle OutputValid=1, OutputData=17'h1ABCD, Count=1.
REQ-032 Write 1, 2, 3, 4 back-to-back, then a 5th write, with OutputReady=0 -> Full=1, Count=4, Overflow=1; draining yields 1, 2, 3, 4, and Full and Count return to 0.
REQ-033 Hold OutputReady=1 and write 10 sequential values 0..9 on consecutive cycles -> Count stays 1 after the first, values emerge in order, and the pointers wrap past DEPTH with no loss.
REQ-034 Full FIFO, drive WriteEnable and OutputReady in the same cycle -> the head is consumed, the write is dropped, Count=3, and Overflow=1.
REQ-035 Overflow=1, drive ClearOverflow together with a dropped write -> Overflow stays 1; ClearOverflow alone on the next cycle -> Overflow=0.
REQ-036 Count=3, assert Reset together with WriteEnable -> Count=0, OutputValid=0, OutputData=0, and the written word is never emitted.

Source files
------------

// File: rtl/output_port_fifo.sv
// output_port_fifo
//   Show-ahead FIFO between the CPU write path and an external consumer.
//   The head word is always presented on OutputData (zero when empty) and
//   handed over on a valid/ready handshake. Writes arriving while Full is
//   high are dropped and latch the sticky Overflow flag.
//
// Ports
//   Clock          rising-edge clock for all state
//   Reset          synchronous, active-high reset
//   WriteEnable    CPU write request
//   WriteData      word written by the CPU
//   Full           count == DEPTH (registered)
//   OutputData     head-of-FIFO word, 0 when empty
//   OutputValid    OutputData holds a valid word
//   OutputReady    consumer accepts OutputData this cycle
//   Count          number of occupied entries
//   Overflow       sticky flag: a write was dropped
//   ClearOverflow  clears Overflow on the next edge (a drop in the same cycle wins)
module output_port_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     WriteEnable,
    input  logic [WIDTH-1:0]         WriteData,
    output logic                     Full,
    output logic [WIDTH-1:0]         OutputData,
    output logic                     OutputValid,
    input  logic                     OutputReady,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    input  logic                     ClearOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             overflow_q;

    logic             wr_accept;
    logic             wr_drop;
    logic             rd_hs;

    // Full is the registered flag, so a read in the same cycle cannot make
    // room for a write: there is no write-through when full.
    assign wr_accept = WriteEnable & ~full_q;
    assign wr_drop   = WriteEnable & full_q;
    assign rd_hs     = OutputValid & OutputReady;

    always_comb begin
        count_d = count_q;
        case ({wr_accept, rd_hs})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so the
    // increment wraps from DEPTH-1 to 0 on its own.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_hs) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (ClearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; its contents are only visible while count != 0.
    always_ff @(posedge Clock) begin
        if (!Reset && wr_accept) begin
            mem[wr_ptr_q] <= WriteData;
        end
    end

    assign OutputValid = (count_q != '0);
    assign OutputData  = OutputValid ? mem[rd_ptr_q] : '0;
    assign Full        = full_q;
    assign Count       = count_q;
    assign Overflow    = overflow_q;

endmodule
